demux_stream: RTL and testbench

Registered 1-to-4 demultiplexer with valid/ready handshaking. It is the receive-side counterpart of the 4:1 `mux_case` selector. A single input stream carries a 2-bit payload and a 2-bit destination select. Each word is steered into one of four 1-deep output registers, and each output channel keeps a saturating count of delivered words. Upstream sees back-pressure only from the selected channel, so other channels never stall it.

---
 rtl/demux_stream.sv | 83 ++++++++
 tb/tb_demux_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready handshaking.
// Each channel owns a 1-deep output register and a saturating delivered-word counter.
module demux_stream #(
    parameter int W  = 2,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    in_data,
    input  logic [1:0]      in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*W-1:0]  out_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    input  logic            cnt_clr,
    output logic [4*CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [3:0]    r_valid;
    logic [W-1:0]  r_data [4];
    logic [CW-1:0] r_cnt  [4];

    logic [3:0]    w_drain;
    logic [3:0]    w_load;
    logic          w_ready;
    logic          w_acc;

    // Only the addressed channel can stall upstream; a draining channel reloads in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before any conditional write, so no latch is inferred.
        w_load  = '0;
        w_drain = r_valid & out_ready;
        w_ready = ~r_valid[in_sel] | out_ready[in_sel];
        w_acc   = in_valid & w_ready;
        if (w_acc) begin
            w_load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload slots are reset as well, because out_data must read zero out of reset.
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // NOTE: non-blocking assignments so every channel updates from pre-edge values.
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (w_drain[k]) begin
                    r_valid[k] <= 1'b0;
                end

                // A clear wins over a same-cycle handshake; that delivery goes uncounted.
                if (cnt_clr) begin
                    r_cnt[k] <= '0;
                end else if (w_drain[k] && (r_cnt[k] != CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        cnt      = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*W +: W] = r_data[k];
            cnt[k*CW +: CW]    = r_cnt[k];
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed tables, corner sequences and a
// randomized run against a per-channel queue model. A CW=2 copy covers saturation.
module tb_demux_stream;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic [3:0]  out_ready;
    logic        cnt_clr;

    logic        in_ready,  in_ready_s;
    logic [7:0]  out_data,  out_data_s;
    logic [3:0]  out_valid, out_valid_s;
    logic [31:0] cnt;
    logic [7:0]  cnt_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_stream #(.W(2), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr), .cnt(cnt)
    );

    demux_stream #(.W(2), .CW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .cnt_clr(cnt_clr), .cnt(cnt_s)
    );

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [1:0]  data;
        logic [3:0]  ordy;
        logic        clr;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [7:0]  exp_od;
        logic [31:0] exp_cnt;
    } vec_t;

    typedef logic [1:0] word_q_t[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d,
                         input logic [3:0] r, input logic c);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        cnt_clr   = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl [5];
    word_q_t     mq [4];
    int unsigned mcnt [4];
    int unsigned mcnt_s [4];
    logic [1:0]  mlast [4];

    initial begin
        tbl[0] = '{1'b1, 2'd0, 2'b00, 4'hF, 1'b0, 1'b1, 4'b0001, 8'h00, 32'h0000_0000};
        tbl[1] = '{1'b1, 2'd1, 2'b01, 4'hF, 1'b0, 1'b1, 4'b0010, 8'h04, 32'h0000_0001};
        tbl[2] = '{1'b1, 2'd2, 2'b10, 4'hF, 1'b0, 1'b1, 4'b0100, 8'h24, 32'h0000_0101};
        tbl[3] = '{1'b1, 2'd3, 2'b11, 4'hF, 1'b0, 1'b1, 4'b1000, 8'hE4, 32'h0001_0101};
        tbl[4] = '{1'b0, 2'd0, 2'b00, 4'hF, 1'b0, 1'b1, 4'b0000, 8'hE4, 32'h0101_0101};

        // Power-on reset, checked before any clock edge.
        drive(1'b0, 2'd0, 2'b00, 4'h0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("reset out_valid", out_valid, 4'b0000);
        check("reset cnt",       cnt,       32'h0);
        check("reset out_data",  out_data,  8'h00);
        check("reset in_ready",  in_ready,  1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Routing sweep.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy, tbl[i].clr);
            check($sformatf("sweep%0d in_ready", i), in_ready, tbl[i].exp_rdy);
            tick();
            check($sformatf("sweep%0d out_valid", i), out_valid, tbl[i].exp_ov);
            check($sformatf("sweep%0d out_data", i),  out_data,  tbl[i].exp_od);
            check($sformatf("sweep%0d cnt", i),       cnt,       tbl[i].exp_cnt);
        end

        // Mid-cycle asynchronous reset with non-zero state.
        drive(1'b0, 2'd0, 2'b00, 4'hF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 4'b0000);
        check("midreset cnt",       cnt,       32'h0);
        check("midreset out_data",  out_data,  8'h00);
        check("midreset in_ready",  in_ready,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-pressure on channel 2, with channel 1 traffic passing it.
        drive(1'b1, 2'd2, 2'b10, 4'b1011, 1'b0);
        check("bp1 in_ready", in_ready, 1'b1);
        tick();
        check("bp1 out_valid", out_valid, 4'b0100);
        check("bp1 slot2", out_data[5:4], 2'b10);
        drive(1'b1, 2'd1, 2'b01, 4'b1011, 1'b0);
        check("nb in_ready", in_ready, 1'b1);
        tick();
        check("nb out_valid", out_valid, 4'b0110);
        check("nb slot1", out_data[3:2], 2'b01);
        check("nb slot2", out_data[5:4], 2'b10);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd2, 2'b11, 4'b1011, 1'b0);
            check($sformatf("stall%0d in_ready", i), in_ready, 1'b0);
            tick();
            check($sformatf("stall%0d out_valid", i), out_valid, 4'b0100);
            check($sformatf("stall%0d slot2", i), out_data[5:4], 2'b10);
            check($sformatf("stall%0d cnt1", i), cnt[15:8], 8'd1);
        end
        drive(1'b1, 2'd2, 2'b11, 4'b1111, 1'b0);
        check("release in_ready", in_ready, 1'b1);
        tick();
        check("release out_valid", out_valid, 4'b0100);
        check("release slot2", out_data[5:4], 2'b11);
        check("release cnt2", cnt[23:16], 8'd1);
        drive(1'b0, 2'd0, 2'b00, 4'b1111, 1'b0);
        tick();
        check("drain out_valid", out_valid, 4'b0000);
        check("drain slot2 hold", out_data[5:4], 2'b11);
        check("drain cnt2", cnt[23:16], 8'd2);

        // Saturation (CW=2 copy) and clear priority.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 2'(i), 4'b1111, 1'b0);
            tick();
        end
        drive(1'b0, 2'd0, 2'b00, 4'b1111, 1'b0);
        tick();
        check("sat cnt_s0", cnt_s[1:0], 2'd3);
        check("sat cnt0",   cnt[7:0],   8'd5);
        check("sat out_valid_s", out_valid_s, 4'b0000);
        drive(1'b1, 2'd0, 2'b10, 4'b1111, 1'b0);
        tick();
        check("preclr out_valid", out_valid, 4'b0001);
        check("preclr cnt0", cnt[7:0], 8'd5);
        drive(1'b0, 2'd0, 2'b00, 4'b1111, 1'b1);
        tick();
        check("clr cnt",       cnt,       32'h0);
        check("clr cnt_s",     cnt_s,     8'h00);
        check("clr out_valid", out_valid, 4'b0000);
        check("clr slot0 hold", out_data[1:0], 2'b10);

        // Randomized run against a queue model, starting from the known post-clear state.
        mlast[0] = 2'b10;
        mlast[1] = 2'b01;
        mlast[2] = 2'b11;
        mlast[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mcnt[k]   = 0;
            mcnt_s[k] = 0;
        end
        begin
            logic       v, c, acc, p_stall, exp_rdy;
            logic [1:0] s, d;
            logic [3:0] r, exp_ov;
            logic [7:0] exp_od, exp_cs;
            logic [31:0] exp_c;
            p_stall = 1'b0;
            v = 1'b0;
            s = 2'd0;
            d = 2'd0;
            for (int it = 0; it < 100; it++) begin
                if (!p_stall) begin
                    v = ($urandom_range(0, 3) != 0);
                    s = 2'($urandom_range(0, 3));
                    d = 2'($urandom_range(0, 3));
                end
                r = 4'($urandom);
                c = ($urandom_range(0, 15) == 0);
                drive(v, s, d, r, c);
                exp_rdy = (mq[s].size() == 0) || r[s];
                check($sformatf("rand%0d in_ready", it), in_ready, exp_rdy);
                acc = v && exp_rdy;
                p_stall = v && !exp_rdy;
                tick();

                for (int k = 0; k < 4; k++) begin
                    if (mq[k].size() != 0 && r[k]) begin
                        void'(mq[k].pop_front());
                        if (mcnt[k] < 255)   mcnt[k]++;
                        if (mcnt_s[k] < 3)   mcnt_s[k]++;
                    end
                    if (c) begin
                        mcnt[k]   = 0;
                        mcnt_s[k] = 0;
                    end
                end
                if (acc) begin
                    mq[s].push_back(d);
                    mlast[s] = d;
                end

                exp_ov = '0;
                exp_od = '0;
                exp_c  = '0;
                exp_cs = '0;
                for (int k = 0; k < 4; k++) begin
                    exp_ov[k]          = (mq[k].size() != 0);
                    exp_od[k*2 +: 2]   = (mq[k].size() != 0) ? mq[k][0] : mlast[k];
                    exp_c[k*8 +: 8]    = 8'(mcnt[k]);
                    exp_cs[k*2 +: 2]   = 2'(mcnt_s[k]);
                end
                check($sformatf("rand%0d out_valid", it), out_valid, exp_ov);
                check($sformatf("rand%0d out_data", it),  out_data,  exp_od);
                check($sformatf("rand%0d cnt", it),       cnt,       exp_c);
                check($sformatf("rand%0d cnt_s", it),     cnt_s,     exp_cs);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
